// File: rtl/lab2_proc_scoreboard.sv
// Register scoreboard: tracks in-flight destinations and answers stall/bypass queries for D-stage sources.
// Optional LAB2_PROC_SCOREBOARD_STATS_EN adds stall_cycles and byp_count counters.
module lab2_proc_scoreboard #(
  parameter int NREGS   = 32,
  parameter int NSTAGES = 3,
  parameter int NSRC    = 2,
  parameter int LATW    = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  issue_val,
  input  logic [$clog2(NREGS)-1:0]              issue_rd,
  input  logic                                  issue_wen,
  input  logic [LATW-1:0]                       issue_lat,
  input  logic                                  wake_val,
  input  logic [$clog2(NREGS)-1:0]              wake_rd,
  input  logic [NSTAGES-1:0]                    stage_adv,
  input  logic                                  flush,
  input  logic [NSRC*$clog2(NREGS)-1:0]         src_addr,
  input  logic [NSRC-1:0]                       src_use,
  output logic [NSRC-1:0]                       src_stall,
  output logic [NSRC*$clog2(NSTAGES+1)-1:0]     src_byp_sel,
  output logic                                  stall_D
`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]                           stall_cycles,
  output logic [31:0]                           byp_count
`endif
);

  localparam int AW = $clog2(NREGS);
  localparam int PW = $clog2(NSTAGES + 1);
  localparam logic [LATW-1:0] LAT_INF = '1;

  logic            pend_reg [NREGS];
  logic [LATW-1:0] cnt_reg  [NREGS];
  logic [PW-1:0]   pos_reg  [NREGS];
  logic            pend_next [NREGS];
  logic [LATW-1:0] cnt_next  [NREGS];
  logic [PW-1:0]   pos_next  [NREGS];

  logic issue_wr;
  assign issue_wr = issue_val & issue_wen & (issue_rd != '0);

  // Priority, lowest to highest: countdown/wake/advance, commit, issue, flush.
  always_comb begin
    logic adv;
    for (int r = 0; r < NREGS; r++) begin
      pend_next[r] = pend_reg[r];
      cnt_next[r]  = cnt_reg[r];
      pos_next[r]  = pos_reg[r];
      adv = 1'b0;
      for (int p = 1; p <= NSTAGES; p++) begin
        if (pos_reg[r] == PW'(p)) adv = stage_adv[p-1];
      end
      if (pend_reg[r]) begin
        if (wake_val && wake_rd == AW'(r))
          cnt_next[r] = '0;
        else if (cnt_reg[r] != '0 && cnt_reg[r] != LAT_INF)
          cnt_next[r] = cnt_reg[r] - LATW'(1);
        if (adv) begin
          if (pos_reg[r] == PW'(NSTAGES)) begin
            pend_next[r] = 1'b0;
            cnt_next[r]  = '0;
            pos_next[r]  = '0;
          end else begin
            pos_next[r] = pos_reg[r] + PW'(1);
          end
        end
      end
      if (issue_wr && issue_rd == AW'(r)) begin
        pend_next[r] = 1'b1;
        cnt_next[r]  = issue_lat;
        pos_next[r]  = PW'(1);
      end
      if (flush || r == 0) begin
        pend_next[r] = 1'b0;
        cnt_next[r]  = '0;
        pos_next[r]  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        pend_reg[r] <= 1'b0;
        cnt_reg[r]  <= '0;
        pos_reg[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        pend_reg[r] <= pend_next[r];
        cnt_reg[r]  <= cnt_next[r];
        pos_reg[r]  <= pos_next[r];
      end
    end
  end

  // Lookups use pre-update state, so an issuing instruction never sees its own write.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = src_addr[gi*AW +: AW];
    assign hit  = src_use[gi] && (addr != '0) && pend_reg[addr];
    assign src_stall[gi] = hit && (cnt_reg[addr] != '0);
    assign src_byp_sel[gi*PW +: PW] = (hit && cnt_reg[addr] == '0) ? pos_reg[addr] : '0;
  end

  assign stall_D = |src_stall;

`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
  logic [31:0] byp_inc;
  always_comb begin
    byp_inc = '0;
    for (int k = 0; k < NSRC; k++) begin
      byp_inc = byp_inc + 32'(|src_byp_sel[k*PW +: PW]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      byp_count    <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(stall_D);
      byp_count    <= byp_count + byp_inc;
    end
  end
`endif

endmodule

// File: tb/tb_lab2_proc_scoreboard.sv
// Directed bench for lab2_proc_scoreboard: a queue-of-producers model checked every cycle,
// plus literal expectations taken from the scenario walkthroughs.
module tb_lab2_proc_scoreboard;
  localparam int NREGS = 32, NSTAGES = 3, NSRC = 2, LATW = 3;
  localparam int AW = $clog2(NREGS);
  localparam int PW = $clog2(NSTAGES + 1);

  logic clk = 1'b0;
  logic reset;
  logic issue_val, issue_wen, wake_val, flush;
  logic [AW-1:0] issue_rd, wake_rd;
  logic [LATW-1:0] issue_lat;
  logic [NSTAGES-1:0] stage_adv;
  logic [NSRC*AW-1:0] src_addr;
  logic [NSRC-1:0] src_use, src_stall;
  logic [NSRC*PW-1:0] src_byp_sel;
  logic stall_D;
`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles, byp_count;
`endif

  int n_checks = 0;
  int n_fail = 0;

  lab2_proc_scoreboard #(.NREGS(NREGS), .NSTAGES(NSTAGES), .NSRC(NSRC), .LATW(LATW)) dut (
    .clk(clk), .reset(reset),
    .issue_val(issue_val), .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_lat(issue_lat),
    .wake_val(wake_val), .wake_rd(wake_rd), .stage_adv(stage_adv), .flush(flush),
    .src_addr(src_addr), .src_use(src_use), .src_stall(src_stall),
    .src_byp_sel(src_byp_sel), .stall_D(stall_D)
`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
    , .stall_cycles(stall_cycles), .byp_count(byp_count)
`endif
  );

  always #5 clk = ~clk;

  // Model: list of in-flight producers, at most one per register (youngest wins).
  typedef struct { int rd; int cnt; int pos; } prod_t;
  prod_t q[$];
  logic [31:0] m_stall, m_byp;

  function automatic void model_lookup(input int addr, input bit use_it, output bit st, output int sel);
    st = 1'b0;
    sel = 0;
    if (use_it && addr != 0) begin
      foreach (q[i]) begin
        if (q[i].rd == addr) begin
          if (q[i].cnt != 0) st = 1'b1;
          else sel = q[i].pos;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    prod_t nq[$];
    prod_t kept[$];
    prod_t e;
    bit st, any_st;
    int sel;
    if (!reset) begin
      q.delete();
      m_stall = 0;
      m_byp = 0;
    end else begin
      any_st = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
        model_lookup(int'(src_addr[k*AW +: AW]), src_use[k], st, sel);
        if (st) any_st = 1'b1;
        if (sel != 0) m_byp = m_byp + 1;
      end
      if (any_st) m_stall = m_stall + 1;
      nq.delete();
      if (!flush) begin
        foreach (q[i]) begin
          e = q[i];
          if (!(e.pos == NSTAGES && stage_adv[NSTAGES-1])) begin
            if (wake_val && int'(wake_rd) == e.rd) e.cnt = 0;
            else if (e.cnt != 0 && e.cnt != (1 << LATW) - 1) e.cnt = e.cnt - 1;
            if (e.pos < NSTAGES && stage_adv[e.pos-1]) e.pos = e.pos + 1;
            nq.push_back(e);
          end
        end
        if (issue_val && issue_wen && issue_rd != 0) begin
          kept.delete();
          foreach (nq[i]) if (nq[i].rd != int'(issue_rd)) kept.push_back(nq[i]);
          e.rd = int'(issue_rd);
          e.cnt = int'(issue_lat);
          e.pos = 1;
          kept.push_back(e);
          nq = kept;
        end
      end
      q = nq;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [NSRC-1:0] es;
    logic [NSRC*PW-1:0] esel;
    bit st;
    int sel;
    for (int k = 0; k < NSRC; k++) begin
      model_lookup(int'(src_addr[k*AW +: AW]), src_use[k], st, sel);
      es[k] = st;
      esel[k*PW +: PW] = PW'(sel);
    end
    chk("cycle_outputs", {57'd0, src_stall, src_byp_sel, stall_D}, {57'd0, es, esel, |es});
`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
    chk("cycle_stall_cycles", {32'd0, stall_cycles}, {32'd0, m_stall});
    chk("cycle_byp_count", {32'd0, byp_count}, {32'd0, m_byp});
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
    issue_val = 1'b0;
    wake_val = 1'b0;
    flush = 1'b0;
  endtask

  task automatic issue(input int rd, input int lat);
    issue_val = 1'b1;
    issue_wen = 1'b1;
    issue_rd = AW'(rd);
    issue_lat = LATW'(lat);
  endtask

  task automatic src(input int k, input int rd, input bit u);
    src_addr[k*AW +: AW] = AW'(rd);
    src_use[k] = u;
  endtask

  function automatic logic [PW-1:0] sel_of(input int k);
    return src_byp_sel[k*PW +: PW];
  endfunction

  initial begin
    reset = 1'b0;
    issue_val = 0; issue_wen = 0; issue_rd = '0; issue_lat = '0;
    wake_val = 0; wake_rd = '0; stage_adv = '0; flush = 0;
    src_addr = '0; src_use = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_stall_D", stall_D, 0);
    chk("reset_byp_sel", src_byp_sel, 0);

    // ALU back-to-back
    stage_adv = 3'b111;
    issue(5, 0); step();
    src(0, 5, 1);
    @(negedge clk); chk("alu_stall", src_stall, 0); chk("alu_sel_x", sel_of(0), 1);
    step(); @(negedge clk); chk("alu_sel_m", sel_of(0), 2);
    step(); @(negedge clk); chk("alu_sel_w", sel_of(0), 3);
    step(); @(negedge clk); chk("alu_sel_commit", sel_of(0), 0);

    // Load-use
    issue(7, 1); step();
    src(0, 7, 1);
    @(negedge clk); chk("ld_stall", stall_D, 1);
    step(); @(negedge clk); chk("ld_nostall", stall_D, 0); chk("ld_sel_m", sel_of(0), 2);
    step(); step();

    // Variable-latency imul held in X
    stage_adv = 3'b110;
    issue(9, 7); step();
    src(0, 9, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("imul_stall", stall_D, 1);
      step();
    end
    wake_val = 1'b1; wake_rd = AW'(9);
    @(negedge clk); chk("imul_wake_cycle_stall", stall_D, 1);
    step(); @(negedge clk); chk("imul_woken_stall", stall_D, 0); chk("imul_sel_x", sel_of(0), 1);
    stage_adv = 3'b111;
    step(); step(); step();

    // WAW and x0
    src_use = '0;
    issue(4, 2); step();
    issue(4, 0); step();
    src(0, 4, 1);
    issue(0, 7); src(1, 0, 1);
    @(negedge clk); chk("waw_stall", src_stall[0], 0); chk("waw_sel", sel_of(0), 1);
    chk("x0_stall", src_stall[1], 0); chk("x0_sel", sel_of(1), 0);
    step(); @(negedge clk); chk("x0_after_issue", {src_stall[1], sel_of(1)}, 0);
    step(); step(); step();

    // Flush
    src_use = '0; stage_adv = 3'b000;
    issue(1, 0); step();
    issue(2, 0); step();
    issue(3, 2); step();
    src(0, 1, 1); src(1, 2, 1);
    @(negedge clk); chk("pre_flush_sel", src_byp_sel, 4'b0101);
    flush = 1'b1; issue(6, 0);
    step();
    @(negedge clk); chk("post_flush_sel", src_byp_sel, 0); chk("post_flush_stall", stall_D, 0);
    src(0, 3, 1); src(1, 6, 1);
    @(negedge clk); chk("flush_drop", {src_stall, src_byp_sel}, 0);

    // Asynchronous reset mid-countdown
    src_use = '0;
    issue(8, 5); step();
    src(0, 8, 1);
    @(negedge clk); chk("cnt_stall", stall_D, 1);
    step();
    #2 reset = 1'b0;
    #1 chk("async_reset_stall", stall_D, 0); chk("async_reset_sel", src_byp_sel, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); chk("after_reset_stall", stall_D, 0);

    // Stall run followed by single-source bypass run
    issue(10, 4); step();
    src(0, 10, 1); src_use[1] = 1'b0;
    repeat (4) step();
    @(negedge clk); chk("run_sel", sel_of(0), 1); chk("run_stall", stall_D, 0);
    repeat (6) step();
    src_use = '0;
    @(negedge clk);
`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
    chk("stats_stall_cycles", {32'd0, stall_cycles}, 64'd4);
    chk("stats_byp_count", {32'd0, byp_count}, 64'd6);
`endif
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
